// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state, word type and layer geometry for the convolution sequencer
package conv_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, CONV, DRAIN} state_t;

    typedef logic [15:0] word_t;

    // Edge length of the active image for a layer; 0 flags an unsupported layer.
    function automatic int layer_edge(input int img_dim, input int kernel_dim, input logic [31:0] layer);
        if (layer == 32'd0) return img_dim;
        else if (layer == 32'd1) return (img_dim - kernel_dim + 1) / 2;
        else return 0;
    endfunction

endpackage

// File: rtl/conv_sequencer_if.sv
// rtl/conv_sequencer_if.sv - control, weight/pixel source and MAC-array signals of the sequencer
interface conv_sequencer_if;
    import conv_pkg::*;

    logic        start;
    logic [31:0] layer_nr;
    logic        w_valid;
    logic        w_ready;
    word_t       w_data;
    logic        px_valid;
    logic        px_ready;
    word_t       px_data;
    logic        weight_we;
    word_t       weight_data;
    logic        conv_en;
    word_t       pixel_in;
    logic        output_valid;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, layer_nr, w_valid, w_data, px_valid, px_data,
        input  w_ready, px_ready, weight_we, weight_data, conv_en, pixel_in,
               output_valid, busy, done, err
    );

    modport slave (
        input  start, layer_nr, w_valid, w_data, px_valid, px_data,
        output w_ready, px_ready, weight_we, weight_data, conv_en, pixel_in,
               output_valid, busy, done, err
    );

endinterface

// File: rtl/conv_pos_counter.sv
// rtl/conv_pos_counter.sv - row/column position of the current pixel within a D x D image
module conv_pos_counter
    import conv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        step,
    input  logic [15:0] d,
    output logic [15:0] row,
    output logic [15:0] col,
    output logic        last
);

    assign last = (row == d - 16'd1) && (col == d - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            row <= '0;
            col <= '0;
        end else if (step) begin
            if (col == d - 16'd1) begin
                col <= '0;
                row <= row + 16'd1;
            end else begin
                col <= col + 16'd1;
            end
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - weight load / pixel stream sequencer for a MAC array
// Optional CONV_SEQ_STALL_CNT_EN adds stall_cnt (CONV cycles without a pixel offered).
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_DIM    = 6,
    parameter int KERNEL_DIM = 3,
    parameter int PIPE_LAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    conv_sequencer_if.slave  bus
`ifdef CONV_SEQ_STALL_CNT_EN
    , output logic [31:0]    stall_cnt
`endif
);

    // Weight words per run: KERNEL_DIM^2 taps plus one bias word.
    localparam logic [15:0] W_LAST     = 16'(KERNEL_DIM * KERNEL_DIM);
    localparam logic [15:0] K_M1       = 16'(KERNEL_DIM - 1);
    localparam logic [15:0] DRAIN_LAST = 16'(PIPE_LAT - 1);

    state_t              state, next;
    logic [15:0]         d_reg, w_cnt, drain_cnt, row, col;
    logic                last, legal, accept, w_xfer, px_xfer, hit, err_q;
    logic [PIPE_LAT-1:0] vshift;
    int                  d_int;

    assign d_int   = layer_edge(IMG_DIM, KERNEL_DIM, bus.layer_nr);
    assign legal   = (bus.layer_nr <= 32'd1) && (d_int >= KERNEL_DIM);
    assign accept  = (state == IDLE) && bus.start && legal;
    assign w_xfer  = (state == LOAD_W) && bus.w_valid;
    assign px_xfer = (state == CONV) && bus.px_valid;
    assign hit     = px_xfer && (row >= K_M1) && (col >= K_M1);

    assign bus.w_ready      = (state == LOAD_W);
    assign bus.px_ready     = (state == CONV);
    assign bus.weight_we    = w_xfer;
    assign bus.weight_data  = w_xfer ? bus.w_data : '0;
    assign bus.conv_en      = px_xfer;
    assign bus.pixel_in     = px_xfer ? bus.px_data : '0;
    assign bus.output_valid = vshift[PIPE_LAT-1];
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DRAIN) && (drain_cnt == DRAIN_LAST);
    assign bus.err          = err_q;

    conv_pos_counter u_pos (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .step  (px_xfer),
        .d     (d_reg),
        .row   (row),
        .col   (col),
        .last  (last)
    );

    always_comb begin
        next = state;
        case (state)
            IDLE:    if (accept) next = LOAD_W;
            LOAD_W:  if (w_xfer && w_cnt == W_LAST) next = CONV;
            CONV:    if (px_xfer && last) next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            d_reg     <= '0;
            w_cnt     <= '0;
            drain_cnt <= '0;
            err_q     <= 1'b0;
            vshift    <= '0;
        end else begin
            state     <= next;
            err_q     <= (state == IDLE) && bus.start && !legal;
            drain_cnt <= (state == DRAIN && next == DRAIN) ? drain_cnt + 16'd1 : '0;
            if (accept) begin
                d_reg <= 16'(d_int);
                w_cnt <= '0;
            end else if (w_xfer) begin
                w_cnt <= w_cnt + 16'd1;
            end
            vshift[0] <= hit;
            for (int i = 1; i < PIPE_LAT; i++) vshift[i] <= vshift[i-1];
        end
    end

`ifdef CONV_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset || accept) stall_cnt <= '0;
        else if (state == CONV && !bus.px_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule
